// File: rtl/press_timer_if.sv
// Signal bundle between press_detection and the press_timer timing source.
// The timer drives the slave side; the consumer (or a bench) uses master.
interface press_timer_if;
  logic        count_trigger_press;
  logic        new_state;
  logic [31:0] count;
  logic        tick;
  logic        count_done;
  logic [15:0] hold_time;
  logic        long_hold;

  modport master (
    output count_trigger_press,
    output new_state,
    input  count,
    input  tick,
    input  count_done,
    input  hold_time,
    input  long_hold
  );

  modport slave (
    input  count_trigger_press,
    input  new_state,
    output count,
    output tick,
    output count_done,
    output hold_time,
    output long_hold
  );
endinterface

// File: rtl/press_timer.sv
// Prescaled debounce counter for press_detection: counts ticks while the trigger is held,
// saturates at MAX_COUNT, then measures hold time and flags long holds.
module press_timer #(
  parameter int unsigned PRESCALE        = 32'd100000,
  parameter int unsigned MAX_COUNT       = 32'd50,
  parameter int unsigned LONG_HOLD_TICKS = 32'd1000
) (
  input  logic          clk,
  input  logic          reset,
  press_timer_if.slave  bus
);

  localparam logic [31:0] PRESCALE_LAST = 32'(PRESCALE - 32'd1);
  localparam logic [31:0] MAX_LIM       = 32'(MAX_COUNT);
  localparam logic [15:0] LONG_LIM      = 16'(LONG_HOLD_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SAT  = 2'd2
  } state_t;

  state_t      state_r, state_nx_s;
  logic [31:0] presc_r, presc_nx_s;
  logic [31:0] count_r, count_nx_s;
  logic        tick_r, tick_nx_s;
  logic        done_r, done_nx_s;
  logic [15:0] hold_r, hold_nx_s;
  logic        long_r, long_nx_s;

  logic        wrap_s;
  logic [31:0] presc_inc_s;
  logic [31:0] count_inc_s;
  logic [15:0] hold_inc_s;

  // Next-state and next-output logic; abort and trigger loss both fall back to a full clear.
  always_comb begin
    state_nx_s  = state_r;
    presc_nx_s  = presc_r;
    count_nx_s  = count_r;
    tick_nx_s   = 1'b0;
    done_nx_s   = 1'b0;
    hold_nx_s   = hold_r;
    long_nx_s   = long_r;

    wrap_s      = (presc_r == PRESCALE_LAST);
    presc_inc_s = wrap_s ? 32'd0 : (presc_r + 32'd1);
    count_inc_s = count_r + 32'd1;
    hold_inc_s  = (hold_r == 16'hFFFF) ? hold_r : (hold_r + 16'd1);

    if (bus.new_state) begin
      state_nx_s = ST_IDLE;
      presc_nx_s = 32'd0;
      count_nx_s = 32'd0;
      hold_nx_s  = 16'd0;
      long_nx_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          presc_nx_s = 32'd0;
          count_nx_s = 32'd0;
          hold_nx_s  = 16'd0;
          long_nx_s  = 1'b0;
          if (bus.count_trigger_press) begin
            state_nx_s = ST_RUN;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!bus.count_trigger_press) begin
            state_nx_s = ST_IDLE;
            presc_nx_s = 32'd0;
            count_nx_s = 32'd0;
          end else begin
            presc_nx_s = presc_inc_s;
            if (wrap_s) begin
              count_nx_s = count_inc_s;
              tick_nx_s  = 1'b1;
              if (count_inc_s == MAX_LIM) begin
                state_nx_s = ST_SAT;
                done_nx_s  = 1'b1;
              end else begin
                state_nx_s = ST_RUN;
              end
            end else begin
              state_nx_s = ST_RUN;
            end
          end
        end
        ST_SAT: begin
          if (!bus.count_trigger_press) begin
            state_nx_s = ST_IDLE;
            presc_nx_s = 32'd0;
            count_nx_s = 32'd0;
            hold_nx_s  = 16'd0;
            long_nx_s  = 1'b0;
          end else begin
            presc_nx_s = presc_inc_s;
            if (wrap_s) begin
              tick_nx_s = 1'b1;
              hold_nx_s = hold_inc_s;
              long_nx_s = (hold_inc_s >= LONG_LIM);
            end else begin
              hold_nx_s = hold_r;
            end
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          presc_nx_s = 32'd0;
          count_nx_s = 32'd0;
          hold_nx_s  = 16'd0;
          long_nx_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      presc_r <= 32'd0;
      count_r <= 32'd0;
      tick_r  <= 1'b0;
      done_r  <= 1'b0;
      hold_r  <= 16'd0;
      long_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      presc_r <= presc_nx_s;
      count_r <= count_nx_s;
      tick_r  <= tick_nx_s;
      done_r  <= done_nx_s;
      hold_r  <= hold_nx_s;
      long_r  <= long_nx_s;
    end
  end

  assign bus.count      = count_r;
  assign bus.tick       = tick_r;
  assign bus.count_done = done_r;
  assign bus.hold_time  = hold_r;
  assign bus.long_hold  = long_r;

endmodule
